// File: rtl/perip_timer_pkg.sv
// Shared register map and bit positions for the perip_timer peripheral.
package perip_timer_pkg;

    localparam int unsigned DATA_BUS = 32;

    typedef enum logic [4:0] {
        REG_CNT_LO = 5'd0,
        REG_CNT_HI = 5'd1,
        REG_CTRL   = 5'd2,
        REG_STATUS = 5'd3
    } reg_idx_e;

    localparam int unsigned CMP_BASE      = 4;
    localparam int unsigned CTRL_RUN_BIT  = 0;
    localparam int unsigned CTRL_IE_LSB   = 1;
    localparam int unsigned STAT_OVF_BIT  = 0;
    localparam int unsigned STAT_PEND_LSB = 1;

    // Word index of CMP_LO for a channel; CMP_HI follows at +1.
    function automatic logic [4:0] cmp_lo_idx(input int unsigned ch);
        return 5'(CMP_BASE + 2 * ch);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock-enable prescaler: one-cycle tick every CLK_DIV cycles while run is high.
module timer_prescaler
    import perip_timer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] phase;

    assign tick = run && (phase == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (!run || (phase == LAST)) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

endmodule

// File: rtl/perip_timer.sv
// Memory-mapped free-running timer: prescaled up-counter, compare channels with
// level IRQs, sticky overflow and a high-word shadow for tear-free reads.
module perip_timer
    import perip_timer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50,
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned N_CMP   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                rw,
    input  logic [DATA_BUS-1:0] addr,
    input  logic [DATA_BUS-1:0] wdata,
    output logic [DATA_BUS-1:0] rdata,
    output logic [N_CMP-1:0]    irq
);
    localparam int unsigned HI_W = CNT_W - DATA_BUS;

    logic [4:0]                     a;
    logic                           wr;
    logic                           rd;
    logic                           tick;
    logic                           wr_cnt_lo;
    logic                           wr_cnt_hi;
    logic                           wr_ctrl;
    logic                           wr_status;
    logic                           cnt_wr;
    logic [CNT_W-1:0]               cnt;
    logic [HI_W-1:0]                shadow;
    logic                           run;
    logic                           ovf;
    logic [N_CMP-1:0]               ie;
    logic [N_CMP-1:0]               pend;
    logic [N_CMP-1:0][DATA_BUS-1:0] cmp_lo_rd;
    logic [N_CMP-1:0][DATA_BUS-1:0] cmp_hi_rd;
    logic [DATA_BUS-1:0]            rd_mux;
    logic                           unused_addr;

    assign a           = addr[4:0];
    assign unused_addr = ^addr[DATA_BUS-1:5];

    assign wr        = ena && rw;
    assign rd        = ena && !rw;
    assign wr_cnt_lo = wr && (a == REG_CNT_LO);
    assign wr_cnt_hi = wr && (a == REG_CNT_HI);
    assign wr_ctrl   = wr && (a == REG_CTRL);
    assign wr_status = wr && (a == REG_STATUS);
    assign cnt_wr    = wr_cnt_lo || wr_cnt_hi;

    timer_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            ie  <= '0;
        end else if (wr_ctrl) begin
            run <= wdata[CTRL_RUN_BIT];
            ie  <= wdata[CTRL_IE_LSB +: N_CMP];
        end
    end

    // A counter write replaces its half and swallows a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (wr_cnt_lo) cnt[DATA_BUS-1:0] <= wdata;
            if (wr_cnt_hi) cnt[CNT_W-1:DATA_BUS] <= wdata[HI_W-1:0];
            if (tick && !cnt_wr) cnt <= cnt + CNT_W'(1);

            if (tick && !cnt_wr && (&cnt)) begin
                ovf <= 1'b1;
            end else if (wr_status && wdata[STAT_OVF_BIT]) begin
                ovf <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_CMP; i++) begin : g_cmp
        localparam logic [4:0] LO_IDX = cmp_lo_idx(i);
        localparam logic [4:0] HI_IDX = LO_IDX + 5'd1;

        logic [CNT_W-1:0] cmp_r;
        logic             irq_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cmp_r <= '1;
            end else if (wr && (a == LO_IDX)) begin
                cmp_r[DATA_BUS-1:0] <= wdata;
            end else if (wr && (a == HI_IDX)) begin
                cmp_r[CNT_W-1:DATA_BUS] <= wdata[HI_W-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                irq_r <= 1'b0;
            end else begin
                irq_r <= ie[i] && pend[i];
            end
        end

        assign pend[i]      = (cnt >= cmp_r);
        assign irq[i]       = irq_r;
        assign cmp_lo_rd[i] = cmp_r[DATA_BUS-1:0];
        assign cmp_hi_rd[i] = DATA_BUS'(cmp_r[CNT_W-1:DATA_BUS]);
    end

    always_comb begin
        rd_mux = '0;
        case (a)
            REG_CNT_LO: rd_mux = cnt[DATA_BUS-1:0];
            REG_CNT_HI: rd_mux = DATA_BUS'(shadow);
            REG_CTRL:   rd_mux = DATA_BUS'({ie, run});
            REG_STATUS: rd_mux = DATA_BUS'({pend, ovf});
            default:    ;
        endcase
        for (int unsigned i = 0; i < N_CMP; i++) begin
            if (a == cmp_lo_idx(i)) rd_mux = cmp_lo_rd[i];
            if (a == cmp_lo_idx(i) + 5'd1) rd_mux = cmp_hi_rd[i];
        end
    end

    // CNT_LO reads capture the live high word so a following CNT_HI read is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            shadow <= '0;
        end else if (rd) begin
            rdata <= rd_mux;
            if (a == REG_CNT_LO) shadow <= cnt[CNT_W-1:DATA_BUS];
        end
    end

endmodule

// File: tb/tb_perip_timer.sv
// Self-checking bench for perip_timer: register table, timing corner sequences,
// then randomized bus traffic against a cycle-level behavioural model.
module tb_perip_timer;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CNT_W   = 64;
    localparam int unsigned N_CMP   = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena   = 1'b0;
    logic             rw    = 1'b0;
    logic [31:0]      addr  = '0;
    logic [31:0]      wdata = '0;
    logic [31:0]      rdata;
    logic [N_CMP-1:0] irq;

    always #5 clk = ~clk;

    perip_timer #(
        .CLK_DIV(CLK_DIV),
        .CNT_W  (CNT_W),
        .N_CMP  (N_CMP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .rw   (rw),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    longint unsigned  m_cnt;
    longint unsigned  m_cmp [N_CMP];
    int unsigned      m_phase;
    bit               m_run;
    bit               m_ovf;
    bit [N_CMP-1:0]   m_ie;
    bit [N_CMP-1:0]   m_irq;
    bit [31:0]        m_shadow;
    bit [31:0]        m_rdata;

    function automatic bit [31:0] model_read(input int unsigned a, input bit [N_CMP-1:0] pend);
        if (a == 0) return m_cnt[31:0];
        if (a == 1) return m_shadow;
        if (a == 2) return 32'({m_ie, m_run});
        if (a == 3) return 32'({pend, m_ovf});
        if (a >= 4 && a < 4 + 2 * N_CMP) begin
            if (a % 2 == 0) return m_cmp[(a - 4) / 2][31:0];
            return m_cmp[(a - 4) / 2][63:32];
        end
        return 32'h0;
    endfunction

    function automatic void model_step();
        int unsigned    a   = int'(addr[4:0]);
        bit             wr  = ena && rw;
        bit             rd  = ena && !rw;
        bit             tck = m_run && (m_phase == CLK_DIV - 1);
        bit             set_ovf = 1'b0;
        bit [N_CMP-1:0] pend;
        for (int i = 0; i < N_CMP; i++) pend[i] = (m_cnt >= m_cmp[i]);

        if (rd) begin
            m_rdata = model_read(a, pend);
            if (a == 0) m_shadow = m_cnt[63:32];
        end
        m_irq   = m_ie & pend;
        m_phase = m_run ? (m_phase + 1) % CLK_DIV : 0;

        if (wr && a == 0)      m_cnt = {m_cnt[63:32], wdata};
        else if (wr && a == 1) m_cnt = {wdata, m_cnt[31:0]};
        else if (tck) begin
            if (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF) set_ovf = 1'b1;
            m_cnt = m_cnt + 1;
        end

        if (set_ovf) m_ovf = 1'b1;
        else if (wr && a == 3 && wdata[0]) m_ovf = 1'b0;

        if (wr && a == 2) begin
            m_run = wdata[0];
            m_ie  = wdata[N_CMP:1];
        end
        if (wr && a >= 4 && a < 4 + 2 * N_CMP) begin
            if (a % 2 == 0) m_cmp[(a - 4) / 2] = {m_cmp[(a - 4) / 2][63:32], wdata};
            else            m_cmp[(a - 4) / 2] = {wdata, m_cmp[(a - 4) / 2][31:0]};
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_phase = 0; m_run = 0; m_ovf = 0;
            m_ie = '0; m_irq = '0; m_shadow = '0; m_rdata = '0;
            for (int i = 0; i < N_CMP; i++) m_cmp[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            model_step();
        end
    end

    // ---------------- bus helpers (called at a negedge) ----------------
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        ena = 1'b1; rw = 1'b1; addr = {27'($urandom), a}; wdata = d;
        @(negedge clk);
        ena = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        ena = 1'b1; rw = 1'b0; addr = {27'($urandom), a}; wdata = $urandom;
        @(negedge clk);
        ena = 1'b0;
        d = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        bit        rw;
        bit [4:0]  a;
        bit [31:0] d;
        bit [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input bit rw_i, input bit [4:0] a_i, input bit [31:0] d_i, input bit [31:0] e_i);
        vec_t v;
        v.rw = rw_i; v.a = a_i; v.d = d_i; v.exp = e_i;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] d;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and basic register behaviour.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 5'(i), 0, 32'h0));
        for (int i = 4; i < 8; i++) tbl.push_back(mk(0, 5'(i), 0, 32'hFFFF_FFFF));
        tbl.push_back(mk(0, 5'd10, 0, 32'h0));
        tbl.push_back(mk(0, 5'd31, 0, 32'h0));
        tbl.push_back(mk(1, 5'd2, 32'h6, 0));
        tbl.push_back(mk(0, 5'd2, 0, 32'h6));
        tbl.push_back(mk(1, 5'd2, 32'h0, 0));
        tbl.push_back(mk(0, 5'd2, 0, 32'h0));
        tbl.push_back(mk(1, 5'd3, 32'h6, 0));
        tbl.push_back(mk(0, 5'd3, 0, 32'h0));
        tbl.push_back(mk(1, 5'd4, 32'h1234_5678, 0));
        tbl.push_back(mk(0, 5'd4, 0, 32'h1234_5678));
        tbl.push_back(mk(0, 5'd5, 0, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 5'd4, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(1, 5'd12, 32'hDEAD_BEEF, 0));
        tbl.push_back(mk(0, 5'd12, 0, 32'h0));
        tbl.push_back(mk(1, 5'd1, 32'h0000_00AB, 0));
        tbl.push_back(mk(0, 5'd1, 0, 32'h0));
        tbl.push_back(mk(0, 5'd0, 0, 32'h0));
        tbl.push_back(mk(0, 5'd1, 0, 32'h0000_00AB));
        tbl.push_back(mk(1, 5'd1, 32'h0, 0));

        check("reset irq", irq, '0);
        check("reset rdata", rdata, 32'h0);
        foreach (tbl[k]) begin
            if (tbl[k].rw) begin
                bus_write(tbl[k].a, tbl[k].d);
            end else begin
                bus_read(tbl[k].a, d);
                check($sformatf("tbl[%0d] addr %0d", k, tbl[k].a), d, tbl[k].exp);
            end
        end

        // Prescaler: RUN set at edge 0, first increment at edge 4.
        bus_write(5'd2, 32'h1);
        idle(3);
        bus_read(5'd0, d); check("presc before tick", d, 32'd0);
        bus_read(5'd0, d); check("presc after tick", d, 32'd1);
        idle(95);
        bus_read(5'd0, d); check("presc 100 cycles", d, 32'd25);

        // Tear-free read across the LO->HI carry.
        bus_write(5'd2, 32'h0);
        bus_write(5'd1, 32'h0);
        bus_write(5'd0, 32'hFFFF_FFFE);
        bus_write(5'd2, 32'h1);
        bus_read(5'd0, d); check("tear lo", d, 32'hFFFF_FFFE);
        idle(7);
        bus_read(5'd1, d); check("tear hi shadow", d, 32'h0);
        bus_read(5'd0, d); check("tear lo after carry", d, 32'h0);
        bus_read(5'd1, d); check("tear hi updated", d, 32'h1);

        // Overflow, then set/clear collision.
        bus_write(5'd2, 32'h0);
        bus_write(5'd1, 32'hFFFF_FFFF);
        bus_write(5'd0, 32'hFFFF_FFFF);
        bus_write(5'd2, 32'h1);
        idle(3);
        bus_read(5'd3, d); check("status at all-ones", d, 32'h6);
        bus_read(5'd3, d); check("ovf after wrap", d, 32'h1);
        bus_read(5'd0, d); check("cnt after wrap", d, 32'h0);
        bus_write(5'd2, 32'h0);
        bus_write(5'd1, 32'hFFFF_FFFF);
        bus_write(5'd0, 32'hFFFF_FFFF);
        bus_write(5'd2, 32'h1);
        idle(3);
        bus_write(5'd3, 32'h1);
        bus_read(5'd3, d); check("ovf set beats clear", d, 32'h1);
        bus_write(5'd3, 32'h1);
        bus_read(5'd3, d); check("ovf cleared", d, 32'h0);

        // Counter write on a tick cycle wins; prescaler phase unaffected.
        bus_write(5'd2, 32'h0);
        bus_write(5'd1, 32'h0);
        bus_write(5'd0, 32'h0);
        bus_write(5'd2, 32'h1);
        idle(3);
        bus_write(5'd0, 32'd7);
        bus_read(5'd0, d); check("cnt write on tick", d, 32'd7);
        idle(3);
        bus_read(5'd0, d); check("next tick after write", d, 32'd8);

        // Compare channel 1 interrupt timing.
        bus_write(5'd2, 32'h0);
        bus_write(5'd0, 32'h0);
        bus_write(5'd1, 32'h0);
        bus_write(5'd6, 32'd10);
        bus_write(5'd7, 32'h0);
        bus_write(5'd2, 32'h5);
        idle(39);
        check("irq before match", irq, 2'b00);
        idle(1);
        check("irq at match cycle", irq, 2'b00);
        idle(1);
        check("irq one cycle after", irq, 2'b10);
        bus_write(5'd7, 32'hFFFF_FFFF);
        check("irq during cmp write", irq, 2'b10);
        idle(1);
        check("irq cleared by cmp", irq, 2'b00);

        // Asynchronous reset mid-count with rdata and irq non-zero.
        bus_write(5'd2, 32'h0);
        bus_write(5'd0, 32'h0);
        bus_write(5'd1, 32'h0);
        bus_write(5'd4, 32'h0);
        bus_write(5'd5, 32'h0);
        bus_write(5'd2, 32'h3);
        idle(6);
        bus_read(5'd0, d); check("pre-reset cnt", d, 32'd1);
        check("pre-reset irq", irq, 2'b01);
        rst_n = 1'b0;
        #1;
        check("async reset rdata", rdata, 32'h0);
        check("async reset irq", irq, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(5'd0, d); check("post-reset cnt", d, 32'h0);
        bus_read(5'd2, d); check("post-reset ctrl", d, 32'h0);
        bus_read(5'd4, d); check("post-reset cmp", d, 32'hFFFF_FFFF);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                int unsigned a;
                logic [31:0] v;
                a = ($urandom_range(0, 20) == 0) ? 31 : $urandom_range(0, 11);
                case (a)
                    0:       v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                              : 32'($urandom_range(0, 300));
                    1, 5, 7: v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'h0;
                    2:       begin v = $urandom; v[0] = ($urandom_range(0, 7) != 0); end
                    4, 6:    v = 32'($urandom_range(0, 400));
                    default: v = $urandom;
                endcase
                ena = 1'b1; rw = $urandom_range(0, 1) == 1;
                addr = {27'($urandom), 5'(a)}; wdata = v;
            end else begin
                ena = 1'b0;
            end
            @(negedge clk);
            check($sformatf("rand[%0d] rdata", k), rdata, m_rdata);
            check($sformatf("rand[%0d] irq", k), irq, m_irq);
        end
        ena = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
